// File: rtl/stage_if.sv
// ----------------------------------------------------------------------------
// stage_if -- instruction fetch stage with a byte-wide memory port.
//
// Each 32-bit instruction is assembled from four byte reads (B0..B3, little
// endian) and handed to decode. The word is held in HOLD until decode
// consumes it. A branch redirect from decode aborts any partial fetch.
//
// Build option:
//   ICACHE_EN  - when defined, adds a 64-entry direct-mapped instruction cache
//                (index pc[7:2], tag pc[31:8]). A hit in B0 skips memory.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   rdy              global ready; low freezes every register
//   stall_i          decode not ready; held word is not consumed
//   branch_enable_i  redirect request from decode
//   branch_addr_i    redirect target (low two bits ignored)
//   mem_req_o        byte fetch request, held until mem_done_i
//   mem_addr_o       byte address of the current request
//   mem_done_i       one-cycle pulse, mem_data_i valid
//   mem_data_i       fetched byte
//   pc_o             address of inst_o
//   inst_o           fetched instruction
//   inst_valid_o     inst_o/pc_o valid for decode
// ----------------------------------------------------------------------------
module stage_if (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_done_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        B3,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] pc;          // fetch pointer, always word aligned
    logic [23:0] word_q;      // bytes 0..2 of the word being assembled
    logic        cache_hit;   // cached copy of word at pc, valid only in B0
    logic        fill_done;   // fourth byte arrives and is not discarded

    // Only the word-aligned part of the redirect target is meaningful.
    logic        unused_branch_bits;
    assign unused_branch_bits = &{1'b0, branch_addr_i[1:0]};

    assign fill_done = rdy && !branch_enable_i && (state == B3) && mem_done_i;

`ifdef ICACHE_EN
    // ------------------------------------------------------------------------
    // Direct-mapped instruction cache. Only the valid bits need reset; the
    // data and tag arrays are qualified by them.
    // ------------------------------------------------------------------------
    logic [31:0] cache_data  [64];
    logic [23:0] cache_tag   [64];
    logic [63:0] cache_valid;
    logic [5:0]  cache_idx;

    always_comb begin
        cache_idx = pc[7:2];
        cache_hit = (state == B0) && cache_valid[cache_idx] &&
                    (cache_tag[cache_idx] == pc[31:8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= '0;
        end else if (fill_done) begin
            cache_valid[cache_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            cache_data[cache_idx] <= {mem_data_i, word_q};
            cache_tag[cache_idx]  <= pc[31:8];
        end
    end
`else
    always_comb begin
        cache_hit = 1'b0;
    end
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. A redirect outranks every other event, including a
    // coincident mem_done_i, and always passes through IDLE so the memory
    // side sees a one-cycle request bubble.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (branch_enable_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = B0;
                B0: begin
                    if (cache_hit) begin
                        state_nx = HOLD;
                    end else if (mem_done_i) begin
                        state_nx = B1;
                    end
                end
                B1: if (mem_done_i) state_nx = B2;
                B2: if (mem_done_i) state_nx = B3;
                B3: if (mem_done_i) state_nx = HOLD;
                HOLD: if (!stall_i) state_nx = B0;
                default: state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side outputs, decoded from state and pc. Both are registers in
    // effect: they only change when state/pc change, so rdy=0 freezes them.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = pc;
        case (state)
            B0: begin
                mem_req_o  = !cache_hit;
                mem_addr_o = pc;
            end
            B1: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc + 32'd1;
            end
            B2: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc + 32'd2;
            end
            B3: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc + 32'd3;
            end
            default: begin
                mem_req_o  = 1'b0;
                mem_addr_o = pc;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: fetch pointer, byte assembly and decode-side outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            word_q       <= '0;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else if (rdy) begin
            if (branch_enable_i) begin
                pc           <= {branch_addr_i[31:2], 2'b00};
                word_q       <= '0;
                inst_valid_o <= 1'b0;
            end else begin
                case (state)
                    B0: begin
`ifdef ICACHE_EN
                        if (cache_hit) begin
                            inst_o       <= cache_data[cache_idx];
                            pc_o         <= pc;
                            inst_valid_o <= 1'b1;
                            pc           <= pc + 32'd4;
                        end else if (mem_done_i) begin
                            word_q[7:0] <= mem_data_i;
                        end
`else
                        if (mem_done_i) begin
                            word_q[7:0] <= mem_data_i;
                        end
`endif
                    end
                    B1: if (mem_done_i) word_q[15:8]  <= mem_data_i;
                    B2: if (mem_done_i) word_q[23:16] <= mem_data_i;
                    B3: begin
                        if (mem_done_i) begin
                            inst_o       <= {mem_data_i, word_q};
                            pc_o         <= pc;
                            inst_valid_o <= 1'b1;
                            pc           <= pc + 32'd4;   // wraps modulo 2^32
                        end
                    end
                    HOLD: if (!stall_i) inst_valid_o <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_i;
    logic [7:0]  mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    // memory responder plus a directed-injection path
    logic        resp_done;
    logic [7:0]  resp_data;
    logic        resp_en;
    logic        inj_done;
    logic [7:0]  inj_data;
    int unsigned lat;
    int unsigned lat_cnt;

    assign mem_done_i = resp_done | inj_done;
    assign mem_data_i = inj_done ? inj_data : resp_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    logic done_seen  = 1'b0;

`ifdef ICACHE_EN
    localparam logic [31:0] EXP_REFETCH_REQ = 32'd0;
`else
    localparam logic [31:0] EXP_REFETCH_REQ = 32'd1;
`endif

    stage_if dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .stall_i        (stall_i),
        .branch_enable_i(branch_enable_i),
        .branch_addr_i  (branch_addr_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_done_i     (mem_done_i),
        .mem_data_i     (mem_data_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory contents
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h00;
            32'd2: return 8'h50;
            32'd3: return 8'h00;
            default: begin
                t = a[7:0] ^ a[15:8] ^ a[31:24];
                return t + 8'h5A;
            end
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2),
                mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = exp_word(a);
        sb.push_back(e);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (inst_valid_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, inst_valid_o}, 32'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int n = 0;
        while (!(mem_req_o === 1'b1 && mem_addr_o === a) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, mem_addr_o, a);
    endtask

    // memory responder: answers a held request after lat idle cycles
    initial begin
        resp_done = 1'b0;
        resp_data = '0;
        lat_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                resp_done = 1'b0;
                lat_cnt   = 0;
            end else if (resp_done) begin
                resp_done = 1'b0;
            end else if (resp_en && mem_req_o) begin
                if (lat_cnt >= lat) begin
                    resp_done = 1'b1;
                    resp_data = mem_byte(mem_addr_o);
                    lat_cnt   = 0;
                end else begin
                    lat_cnt++;
                end
            end
        end
    end

    // scoreboard monitor: each new valid word pops one expectation
    always @(posedge clk) done_seen <= mem_done_i;

    always @(negedge clk) begin
        if (inst_valid_o === 1'b1 && prev_valid !== 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected: got word at pc %h expected none", pc_o);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                total++;
                assert (pc_o === mon_e.pc) else begin
                    bad++;
                    $error("FAIL sb_pc: got %h expected %h", pc_o, mon_e.pc);
                end
                total++;
                assert (inst_o === mon_e.inst) else begin
                    bad++;
                    $error("FAIL sb_inst: got %h expected %h", inst_o, mon_e.inst);
                end
            end
        end
        prev_valid <= inst_valid_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        rdy             = 1'b1;
        stall_i         = 1'b1;
        branch_enable_i = 1'b0;
        branch_addr_i   = '0;
        inj_done        = 1'b0;
        inj_data        = '0;
        resp_en         = 1'b1;
        lat             = 1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_pc_o",   pc_o, 32'd0);
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_valid",  {31'b0, inst_valid_o}, 32'd0);
        chk("rst_req",    {31'b0, mem_req_o}, 32'd0);
        chk("rst_addr",   mem_addr_o, 32'd0);

        // first fetch from address 0
        rst = 1'b0;
        push_exp(32'd0);
        @(negedge clk);
        chk("first_req",  {31'b0, mem_req_o}, 32'd1);
        chk("first_addr", mem_addr_o, 32'd0);
        wait_valid("first_valid");
        chk("latency_done", {31'b0, done_seen}, 32'd1);

        // held under stall
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, inst_valid_o}, 32'd1);
            chk("stall_inst",  inst_o, 32'h0050_0013);
            chk("stall_pc",    pc_o, 32'd0);
            chk("stall_req",   {31'b0, mem_req_o}, 32'd0);
            @(negedge clk);
        end
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        chk("consume_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("consume_req",   {31'b0, mem_req_o}, 32'd1);
        chk("consume_addr",  mem_addr_o, 32'd4);
        push_exp(32'd4);
        wait_valid("w4_valid");

        // rdy=0 freeze in B1
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        push_exp(32'd8);
        wait_addr("reach_b1", 32'd9);
        rdy     = 1'b0;
        resp_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_req",   {31'b0, mem_req_o}, 32'd1);
            chk("frz_addr",  mem_addr_o, 32'd9);
            chk("frz_valid", {31'b0, inst_valid_o}, 32'd0);
        end
        rdy     = 1'b1;
        resp_en = 1'b1;
        wait_valid("w8_valid");

        // branch during B2 with a coincident mem_done_i
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        wait_addr("reach_b2", 32'd14);
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'h0000_0103;
        inj_done        = 1'b1;
        inj_data        = 8'hEE;
        @(negedge clk);
        branch_enable_i = 1'b0;
        inj_done        = 1'b0;
        chk("br_bubble_req", {31'b0, mem_req_o}, 32'd0);
        chk("br_valid",      {31'b0, inst_valid_o}, 32'd0);
        @(negedge clk);
        chk("br_req",  {31'b0, mem_req_o}, 32'd1);
        chk("br_addr", mem_addr_o, 32'h0000_0100);
        push_exp(32'h0000_0100);
        wait_valid("w100_valid");

        // reset while in B3
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        wait_addr("reach_b3", 32'h0000_0107);
        rst = 1'b1;
        @(negedge clk);
        chk("rstb3_pc_o",   pc_o, 32'd0);
        chk("rstb3_inst_o", inst_o, 32'd0);
        chk("rstb3_valid",  {31'b0, inst_valid_o}, 32'd0);
        chk("rstb3_req",    {31'b0, mem_req_o}, 32'd0);
        chk("rstb3_addr",   mem_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_exp(32'd0);
        @(negedge clk);
        chk("refetch_req",  {31'b0, mem_req_o}, 32'd1);
        chk("refetch_addr", mem_addr_o, 32'd0);
        wait_valid("refetch_valid");

        // loop back to 0: a cache hit skips memory
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        wait_addr("reach_w4_b1", 32'd5);
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'd0;
        @(negedge clk);
        branch_enable_i = 1'b0;
        chk("loop_bubble_req", {31'b0, mem_req_o}, 32'd0);
        @(negedge clk);
        chk("loop_b0_req",  {31'b0, mem_req_o}, EXP_REFETCH_REQ);
        chk("loop_b0_addr", mem_addr_o, 32'd0);
        push_exp(32'd0);
`ifdef ICACHE_EN
        @(negedge clk);
        chk("hit_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("hit_nodone", {31'b0, done_seen}, 32'd0);
`else
        wait_valid("loop_valid");
`endif

        // pc wrap from 0xFFFFFFFC
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'hFFFF_FFFF;
        @(negedge clk);
        branch_enable_i = 1'b0;
        push_exp(32'hFFFF_FFFC);
        wait_valid("top_valid");
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        chk("wrap_addr", mem_addr_o, 32'd0);
        push_exp(32'd0);
        wait_valid("wrap_valid");

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: rdy  in  1  global ready; low freezes all state and outputs.
REQ-004 SHALL have ports: stall_i  in  1  downstream stall; instruction not consumed while high.
REQ-005 SHALL have ports: branch_enable_i  in  1  redirect request from decode.
REQ-006 SHALL have ports: branch_addr_i  in  32  redirect target.
REQ-007 SHALL have ports: mem_req_o  out  1  byte fetch request, held until served.
REQ-008 SHALL have ports: mem_addr_o  out  32  byte address of current request.
REQ-009 SHALL have ports: mem_done_i  in  1  one-cycle pulse, mem_data_i valid.
REQ-010 SHALL have ports: mem_data_i  in  8  fetched byte.
REQ-011 SHALL have ports: pc_o  out  32  address of inst_o.
REQ-012 SHALL have ports: inst_o  out  32  fetched instruction.
REQ-013 SHALL have ports: inst_valid_o  out  1  inst_o/pc_o valid for decode.

Function
REQ-014 SHALL implement states IDLE, B0, B1, B2, B3, HOLD; internal fetch pointer pc.
REQ-015 SHALL, in IDLE, move to B0 next cycle; mem_req_o low in IDLE.
REQ-016 SHALL, in Bk (k=0..3), drive mem_req_o=1 and mem_addr_o=pc+k; on mem_done_i, latch mem_data_i into word bits [8k+7:8k] (little-endian) and advance to B(k+1).
REQ-017 SHALL, on mem_done_i in B3, load inst_o=assembled word, pc_o=pc, inst_valid_o=1 next cycle, set pc=pc+4 and enter HOLD.
REQ-018 SHALL, in HOLD, keep inst_o/pc_o/inst_valid_o stable while stall_i=1; when stall_i=0 the word is consumed: inst_valid_o=0 next cycle, state B0 (back-to-back fetch).
REQ-019 SHALL give branch_enable_i priority over all events except rst: next cycle pc={branch_addr_i[31:2],2'b00}, partial word discarded, inst_valid_o=0, state IDLE (one-cycle mem_req_o=0 bubble).
REQ-020 SHALL ignore a mem_done_i coinciding with branch_enable_i.
REQ-021 SHALL hold every register, including mem_req_o/mem_addr_o, while rdy=0; rdy has priority below rst only.
REQ-022 SHALL wrap pc modulo 2^32 (0xFFFFFFFC+4=0).
REQ-023 SHALL have uncached latency: inst_valid_o exactly one cycle after fourth mem_done_i.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set state IDLE, pc=0, pc_o=0, inst_o=0, inst_valid_o=0, mem_req_o=0, mem_addr_o=0, clearing any fetch in flight.
REQ-025 SHALL fetch from address 0 first after reset release.

Configuration
REQ-026 SHALL, with ICACHE_EN defined, include a 64-entry direct-mapped instruction cache: index pc[7:2], tag pc[31:8], one valid bit per entry cleared by rst.
REQ-027 SHALL, with ICACHE_EN defined, on hit when entering B0, skip memory (mem_req_o stays 0) and present the cached word with inst_valid_o=1 the next cycle, entering HOLD.
REQ-028 SHALL, with ICACHE_EN defined, write each completed B3 word into its entry; a branch discards the partial word without writing.
REQ-029 SHALL, without ICACHE_EN, contain no cache storage; every fetch goes through B0..B3.

Verification
REQ-030 SHALL cover: reset, memory returns 13,00,50,00 at addresses 0..3 -> inst_o=0x00500013, pc_o=0, inst_valid_o=1.
REQ-031 SHALL cover: stall_i=1 for 5 cycles after inst_valid_o -> outputs stable; next mem_addr_o=4 only after stall_i=0.
REQ-032 SHALL cover: branch_enable_i=1, branch_addr_i=0x103 during B2 -> mem_req_o=0 one cycle, then mem_addr_o=0x100, no valid for the aborted word.
REQ-033 SHALL cover: rdy=0 for 3 cycles mid-B1 with mem_done_i low -> no state change, mem_addr_o unchanged.
REQ-034 SHALL cover: ICACHE_EN, loop branch back to 0x0 after first pass -> second fetch of 0x0 has mem_req_o=0 and inst_valid_o one cycle after B0 entry.
REQ-035 SHALL cover: rst asserted in B3 -> all outputs zero next cycle, refetch from 0.
